// File: rtl/seq_mult_shadd.sv
// seq_mult_shadd: sequential shift-and-add unsigned multiplier.
//
// One add per cycle through an 8-bit Ladner-Fischer adder (lf_adder8, below).
// The multiplicand is zero-extended to 8 bits, so the product a*b always fits.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid (sampled only in IDLE)
//   in_ready   high in IDLE
//   a, b       W-bit unsigned multiplicand / multiplier
//   out_valid  product valid (DONE state)
//   out_ready  consumer accepts product (sampled only in DONE)
//   product    8-bit product, registered
//   busy       high in RUN or DONE
//
// Build option: define SEQ_MULT_EARLY_TERM_EN to leave RUN as soon as no
// multiplier ones remain. Without it, RUN lasts exactly W cycles.

module lf_adder8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] sum
);
  logic [7:0] g, p, gp, pp;

  // Prefix tree over (generate, propagate); gp[i] ends up as the carry out of bit i.
  always_comb begin
    g  = x & y;
    p  = x ^ y;
    gp = g;
    pp = p;
    // level 1: pairs
    for (int unsigned i = 1; i < 8; i += 2) begin
      gp[i] = gp[i] | (pp[i] & gp[i-1]);
      pp[i] = pp[i] & pp[i-1];
    end
    // level 2: bits 2,3 from group [1:0]; bits 6,7 from group [5:4]
    for (int unsigned i = 0; i < 8; i++) begin
      if ((i % 4) >= 2) begin
        gp[i] = gp[i] | (pp[i] & gp[(i/4)*4+1]);
        pp[i] = pp[i] & pp[(i/4)*4+1];
      end
    end
    // level 3: upper nibble from group [3:0]
    for (int unsigned i = 4; i < 8; i++) begin
      gp[i] = gp[i] | (pp[i] & gp[3]);
      pp[i] = pp[i] & pp[3];
    end
    sum = p ^ {gp[6:0], 1'b0};
  end
endmodule

module seq_mult_shadd #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   product,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_nxt;
  logic [7:0]   acc, mcand_r, sum;
  logic [W-1:0] mplier_r;
  logic [1:0]   cnt;
  logic         run_last;

  lf_adder8 u_add (
    .x   (acc),
    .y   (mcand_r),
    .sum (sum)
  );

`ifdef SEQ_MULT_EARLY_TERM_EN
  assign run_last = (cnt == 2'(W-1)) || ((mplier_r >> 1) == '0);
`else
  assign run_last = (cnt == 2'(W-1));
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (run_last)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          acc      <= '0;
          mcand_r  <= {{(8-W){1'b0}}, a};
          mplier_r <= b;
          cnt      <= '0;
        end
        RUN: begin
          if (mplier_r[0]) acc <= sum;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt      <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign product   = acc;
endmodule

// File: tb/tb_seq_mult_shadd.sv
module tb_seq_mult_shadd;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] product;
  logic       busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_mult_shadd #(.W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
    int         lat_full;
    int         lat_early;
    int         stall;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pick_lat(input int full, input int early);
`ifdef SEQ_MULT_EARLY_TERM_EN
    return early;
`else
    return full;
`endif
  endfunction

  // Waits for out_valid after an acceptance edge; returns edges counted (99 on timeout).
  task automatic wait_done(output int n);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_op(input vec_t v);
    int n;
    @(negedge clk);
    out_ready = (v.stall == 0);
    in_valid = 1'b1; a = v.a; b = v.b;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 4'hF; b = 4'hF;   // post-acceptance changes must not matter
    check("busy_after_accept", busy, 1);
    wait_done(n);
    check($sformatf("latency %0d*%0d", v.a, v.b), n, pick_lat(v.lat_full, v.lat_early));
    check($sformatf("product %0d*%0d", v.a, v.b), product, v.p);
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_product", product, v.p);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  initial begin
    int n;
    tbl[0] = '{a:4'd13, b:4'd11, p:8'd143, lat_full:4, lat_early:4, stall:0};
    tbl[1] = '{a:4'd15, b:4'd15, p:8'd225, lat_full:4, lat_early:4, stall:0};
    tbl[2] = '{a:4'd0,  b:4'd9,  p:8'd0,   lat_full:4, lat_early:4, stall:0};
    tbl[3] = '{a:4'd6,  b:4'd7,  p:8'd42,  lat_full:4, lat_early:3, stall:5};
    tbl[4] = '{a:4'd7,  b:4'd1,  p:8'd7,   lat_full:4, lat_early:1, stall:0};
    tbl[5] = '{a:4'd7,  b:4'd5,  p:8'd35,  lat_full:4, lat_early:3, stall:0};
    tbl[6] = '{a:4'd9,  b:4'd0,  p:8'd0,   lat_full:4, lat_early:1, stall:0};
    tbl[7] = '{a:4'd1,  b:4'd8,  p:8'd8,   lat_full:4, lat_early:4, stall:2};

    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 0);
    check("rst_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_op(tbl[i]);

    // Busy rejection: second pair held on the inputs during RUN/DONE.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; a = 4'd5; b = 4'd9;
    @(posedge clk); #1;
    a = 4'd3; b = 4'd3;
    check("rej_in_ready", in_ready, 0);
    wait_done(n);
    check("rej_latency", n, 4);
    check("rej_product", product, 45);
    @(posedge clk); #1;
    check("rej_idle", in_ready, 1);
    @(posedge clk); #1;                     // second pair accepted here
    in_valid = 1'b0;
    check("rej2_busy", busy, 1);
    wait_done(n);
    check("rej2_latency", n, pick_lat(4, 2));
    check("rej2_product", product, 9);
    @(posedge clk); #1;
    check("rej2_idle", in_ready, 1);

    // Reset in the second RUN cycle.
    @(negedge clk);
    in_valid = 1'b1; a = 4'd12; b = 4'd12;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_product", product, 0);
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("no_valid_after_rst", n, 0);
    begin
      vec_t v;
      v = '{a:4'd2, b:4'd3, p:8'd6, lat_full:4, lat_early:2, stall:0};
      run_op(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/seq_mult_shadd.md
Name: seq_mult_shadd

Overview:
- Sequential shift-and-add unsigned multiplier that drives the team's 8-bit Ladner-Fischer adder.
- Instantiates the adder internally, feeds it {accumulator, shifted multiplicand} each cycle, and registers its 8-bit sum back into the accumulator.
- Sits between an operand producer and a result consumer. Both sides use valid/ready handshakes.

Parameters:
- W, 4, operand width in bits. Legal range 1..4. Operands are zero-extended to 8 bits for the adder, so the product always fits in 8 bits.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a  in  W  multiplicand, unsigned
- b  in  W  multiplier, unsigned
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- product  out  8  a*b, zero-extended
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, acc=0, mcand_r=0, mplier_r=0, cnt=0.
  - Outputs: in_ready=1, out_valid=0, product=0, busy=0.
  - All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load mcand_r={0,a} (8 bits), mplier_r=b, acc=0, cnt=0; go to RUN.
- RUN (in_ready=0, busy=1), every cycle:
  - If mplier_r[0]=1, acc<=adder_sum(acc, mcand_r); otherwise acc is held.
  - mcand_r<<=1 (zero fill); mplier_r>>=1; cnt<=cnt+1.
  - Exit to DONE on the edge where cnt==W-1. RUN therefore lasts exactly W cycles.
- DONE:
  - out_valid=1, product=acc, held stable while out_ready=0.
  - On an edge with out_ready=1: go to IDLE. out_valid drops and in_ready rises on that same edge.
- Latency: operand accepted at edge k; DONE entered (out_valid high) at edge k+W, i.e. k+4 at W=4.
- Initiation interval: at least W+2 cycles. Operands are never accepted outside IDLE.
- in_valid, a and b are ignored while busy. Operand changes after acceptance do not affect the result.
- Arithmetic:
  - Maximum product (2^W-1)^2 <= 225 < 256, so adder carry-out is never needed and product is exact.
  - Shifted bits of mcand_r beyond bit 7 are discarded. For W<=4 they are always zero.
- Reset mid-operation: the result is lost immediately; no out_valid is produced for the aborted pair. After reset release the block is in IDLE with in_ready=1.
- out_ready is ignored outside DONE.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN
- Defined:
  - In RUN, also exit to DONE when (mplier_r>>1)==0, i.e. no remaining multiplier ones after the current cycle's add.
  - Latency becomes k+max(1, index of highest set bit of b +1).
  - b=0 and b=1 both reach DONE at edge k+1.
  - Product values are identical to the non-early build.
- Undefined: fixed W-cycle RUN regardless of operand values.

Test Plan:
- Basic: W=4, a=13, b=11, out_ready=1 -> product=0x8F (143); out_valid rises exactly 4 edges after acceptance; in_ready=1 one cycle after the DONE handshake.
- Max operands: a=15, b=15 -> product=225 (0xE1). Zero operands: a=0, b=9 -> product=0. Both with the full 4-cycle latency when the macro is undefined.
- Backpressure: a=6, b=7 with out_ready held low 5 cycles after out_valid -> product=42 stable and out_valid held throughout; single transfer when out_ready rises.
- Busy rejection: second pair (a=3, b=3) presented with in_valid=1 during RUN -> ignored; first result a=5, b=9 -> 45 correct; second pair accepted only once back in IDLE -> 9.
- Reset mid-op: assert rst_n=0 during the second RUN cycle of a=12, b=12 -> all outputs reset at once; no out_valid after release; next pair a=2, b=3 -> 6.
- With SEQ_MULT_EARLY_TERM_EN: a=7, b=1 -> product=7 at edge k+1; a=7, b=5 -> 35 at edge k+3; a=9, b=0 -> 0 at edge k+1.
